// File: rtl/vec_alu_sequencer_if.sv
// Issue/result handshakes and shared scalar ALU connection for the vector ALU sequencer.
// The master side is the surrounding environment (issue stage, consumer and scalar ALU).
interface vec_alu_sequencer_if #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32
);
    localparam int VW = LANES * LANE_W;

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_ctrl;
    logic [VW-1:0]     in_a;
    logic [VW-1:0]     in_b;
    logic              flush;

    logic              alu_en;
    logic [2:0]        alu_ctrl;
    logic [LANE_W-1:0] alu_a;
    logic [LANE_W-1:0] alu_b;
    logic [LANE_W-1:0] alu_result;

    logic              out_valid;
    logic              out_ready;
    logic [VW-1:0]     out_result;
    logic              out_zero;
    logic              out_err;

    modport master (
        output in_valid, in_ctrl, in_a, in_b, flush, alu_result, out_ready,
        input  in_ready, alu_en, alu_ctrl, alu_a, alu_b,
               out_valid, out_result, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_ctrl, in_a, in_b, flush, alu_result, out_ready,
        output in_ready, alu_en, alu_ctrl, alu_a, alu_b,
               out_valid, out_result, out_zero, out_err
    );
endinterface

// File: rtl/vec_alu_sequencer.sv
// Runs one vector ALU operation through a shared scalar ALU, one lane per cycle,
// and returns the assembled vector with zero/error flags.
//
// state | meaning
// IDLE  | ready for a new operation
// RUN   | driving the shared ALU with lane cnt, capturing its result
// DONE  | result presented, waiting for out_ready
module vec_alu_sequencer #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    vec_alu_sequencer_if.slave    bus
);
    localparam int VW = LANES * LANE_W;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    ctrl_q;
    logic [VW-1:0] a_q;
    logic [VW-1:0] b_q;
    logic [VW-1:0] res_q;
    logic          err_q;

    logic          accept;
    logic          supported;
    logic          last_lane;

    always_comb begin
        supported = 1'b0;
        case (bus.in_ctrl)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b101: supported = 1'b1;
            default:                                supported = 1'b0;
        endcase
    end

    // flush blocks acceptance even though in_ready is high in IDLE
    assign accept    = bus.in_valid && (state_q == IDLE) && !bus.flush;
    assign last_lane = (cnt_q == CW'(LANES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = supported ? RUN : DONE;
                RUN:  if (last_lane) state_d = DONE;
                DONE: if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            ctrl_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else if (bus.flush) begin
            // result intentionally kept; it is cleared on the next accept
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ctrl_q <= bus.in_ctrl;
                        a_q    <= bus.in_a;
                        b_q    <= bus.in_b;
                        res_q  <= '0;
                        cnt_q  <= '0;
                        err_q  <= !supported;
                    end
                end
                RUN: begin
                    res_q[cnt_q*LANE_W +: LANE_W] <= bus.alu_result;
                    cnt_q <= last_lane ? '0 : cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.in_ready = (state_q == IDLE);
        bus.alu_en   = 1'b0;
        bus.alu_ctrl = 3'b000;
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        if (state_q == RUN) begin
            bus.alu_en   = 1'b1;
            bus.alu_ctrl = ctrl_q;
            bus.alu_a    = a_q[cnt_q*LANE_W +: LANE_W];
            bus.alu_b    = b_q[cnt_q*LANE_W +: LANE_W];
        end
    end

    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q;
    assign bus.out_zero   = ~|res_q;
    assign bus.out_err    = err_q;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Directed bench for vec_alu_sequencer: reference scalar ALU on the alu_* port,
// expected vectors queued at issue and compared when out_valid appears.
module tb_vec_alu_sequencer;
    localparam int LANES  = 8;
    localparam int LANE_W = 32;
    localparam int VW     = LANES * LANE_W;

    typedef struct {
        logic [2:0]    ctrl;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [VW-1:0] res;
        logic          zero;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];
    exp_t last_exp;

    always #5 clk = ~clk;

    vec_alu_sequencer_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

    vec_alu_sequencer #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [LANE_W-1:0] alu_ref(input logic [2:0] c,
                                                  input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return {{(LANE_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: return '0;
        endcase
    endfunction

    assign bus.alu_result = alu_ref(bus.alu_ctrl, bus.alu_a, bus.alu_b);

    function automatic logic [VW-1:0] vec_ref(input logic [2:0] c,
                                              input logic [VW-1:0] a,
                                              input logic [VW-1:0] b);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[i*LANE_W +: LANE_W] = alu_ref(c, a[i*LANE_W +: LANE_W], b[i*LANE_W +: LANE_W]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [2:0] c, input logic [VW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_ctrl  = c;
        bus.in_a     = a;
        bus.in_b     = b;
        e.ctrl = c;
        e.a    = a;
        e.b    = b;
        e.err  = (c == 3'b100) || (c == 3'b110) || (c == 3'b111);
        e.res  = e.err ? '0 : vec_ref(c, a, b);
        e.zero = (e.res == '0);
        sbq.push_back(e);
    endtask

    // Called at the negedge before the accepting posedge; returns at the first negedge with out_valid.
    task automatic collect(input int exp_lat);
        exp_t e;
        int   en_cnt = 0;
        int   lat    = 0;
        bit   got    = 0;
        checks++;
        assert (sbq.size() > 0) else begin
            failures++;
            $error("FAIL sb_empty observed=%0d expected=%0d", sbq.size(), 1);
        end
        if (sbq.size() > 0) e = sbq.pop_front();
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.in_valid = 1'b0;
            if (bus.alu_en === 1'b1) begin
                if (en_cnt < LANES) begin
                    check("alu_a", bus.alu_a, e.a[en_cnt*LANE_W +: LANE_W]);
                    check("alu_b", bus.alu_b, e.b[en_cnt*LANE_W +: LANE_W]);
                    check("alu_ctrl", bus.alu_ctrl, e.ctrl);
                end
                en_cnt++;
            end
            if (bus.out_valid === 1'b1) begin
                got = 1;
                lat = cyc;
                break;
            end
        end
        check("out_valid_seen", got, 1'b1);
        check("latency", lat, exp_lat);
        check("alu_en_cycles", en_cnt, e.err ? 0 : LANES);
        check("out_result", bus.out_result, e.res);
        check("out_zero", bus.out_zero, e.zero);
        check("out_err", bus.out_err, e.err);
        last_exp = e;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_alu_en"}, bus.alu_en, 1'b0);
    endtask

    initial begin
        logic [VW-1:0] a, b, partial;
        bit            leaked;

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ctrl   = 3'b000;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        #1;
        check_idle_outputs("reset");
        check("reset_out_result", bus.out_result, '0);
        check("reset_out_zero", bus.out_zero, 1'b1);
        check("reset_out_err", bus.out_err, 1'b0);
        check("reset_alu_a", bus.alu_a, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // add: lane i = (i+1) + 0x10
        @(negedge clk);
        for (int i = 0; i < LANES; i++) begin
            a[i*LANE_W +: LANE_W] = LANE_W'(i + 1);
            b[i*LANE_W +: LANE_W] = 32'h10;
        end
        check("add_in_ready", bus.in_ready, 1'b1);
        drive_op(3'b000, a, b);
        collect(LANES + 1);
        for (int i = 0; i < LANES; i++)
            check("add_lane", bus.out_result[i*LANE_W +: LANE_W], LANE_W'(32'h11 + i));
        @(negedge clk);
        check_idle_outputs("add_after");

        // sub to zero
        a = {(VW/8){8'hA5}};
        drive_op(3'b001, a, a);
        collect(LANES + 1);
        check("sub_zero_result", bus.out_result, '0);
        check("sub_zero_flag", bus.out_zero, 1'b1);
        @(negedge clk);

        // unsupported code
        drive_op(3'b110, {8{32'hDEADBEEF}}, {8{32'h12345678}});
        collect(1);
        @(negedge clk);

        // slt with mixed signs
        for (int i = 0; i < LANES; i++) begin
            a[i*LANE_W +: LANE_W] = $urandom;
            b[i*LANE_W +: LANE_W] = $urandom;
        end
        a[31:0] = 32'hFFFF_FFFF;
        b[31:0] = 32'h0000_0001;
        drive_op(3'b101, a, b);
        collect(LANES + 1);
        check("slt_lane0", bus.out_result[31:0], 32'd1);
        @(negedge clk);

        // backpressure with a new request waiting
        bus.out_ready = 1'b0;
        drive_op(3'b010, {8{32'hF0F0_1234}}, {8{32'h0FF0_FFFF}});
        collect(LANES + 1);
        for (int i = 0; i < LANES; i++) begin
            a[i*LANE_W +: LANE_W] = LANE_W'(32'h100 * i);
            b[i*LANE_W +: LANE_W] = LANE_W'(i);
        end
        drive_op(3'b011, a, b);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_out_result", bus.out_result, last_exp.res);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_idle_outputs("bp_handshake");
        collect(LANES + 1);
        @(negedge clk);

        // flush during lane 4 of an or
        for (int i = 0; i < LANES; i++) begin
            a[i*LANE_W +: LANE_W] = LANE_W'(32'h0001_0000 << i);
            b[i*LANE_W +: LANE_W] = LANE_W'(32'hA0 + i);
        end
        bus.in_valid = 1'b1;
        bus.in_ctrl  = 3'b011;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("accept_clears_result", bus.out_result, '0);
        repeat (4) @(negedge clk);
        check("flush_lane4_alu_a", bus.alu_a, a[4*LANE_W +: LANE_W]);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check_idle_outputs("flush");
        partial = vec_ref(3'b011, a, b);
        partial[VW-1:4*LANE_W] = '0;
        check("flush_keeps_partial", bus.out_result, partial);
        check("flush_err", bus.out_err, 1'b0);
        leaked = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.alu_en !== 1'b0) leaked = 1;
        end
        check("flush_no_output", leaked, 1'b0);
        drive_op(3'b010, {8{32'hFFFF_0000}}, {8{32'h00FF_FF00}});
        collect(LANES + 1);
        @(negedge clk);

        // flush with in_valid in IDLE: request must be dropped
        bus.in_valid = 1'b1;
        bus.in_ctrl  = 3'b000;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check_idle_outputs("flush_idle");
        @(negedge clk);
        check("flush_idle_no_run", bus.alu_en, 1'b0);

        // asynchronous reset mid-RUN
        bus.in_valid = 1'b1;
        bus.in_ctrl  = 3'b000;
        bus.in_a     = {8{32'h1111_1111}};
        bus.in_b     = {8{32'h2222_2222}};
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("rst_run");
        check("rst_run_out_zero", bus.out_zero, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_release");
        check("rst_release_result", bus.out_result, '0);
        check("rst_release_zero", bus.out_zero, 1'b1);
        drive_op(3'b001, {8{32'h0000_0005}}, {8{32'h0000_0007}});
        collect(LANES + 1);
        @(negedge clk);

        check("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/vec_alu_sequencer.md
# vec_alu_sequencer

Multi-cycle sequencer that runs one 256-bit vector ALU operation through a single shared 32-bit scalar ALU, one lane per cycle. It sits between the vector issue stage and the scalar ALU. It takes the 3-bit ALU control code produced by the ALU decoder and both 256-bit operands over a valid/ready handshake. It returns the assembled 256-bit result with a zero flag over a second valid/ready handshake.

## Interface
- LANES, 8, number of lanes per vector
- LANE_W, 32, lane width in bits; vector width VW = LANES*LANE_W (256)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  sequencer can accept an operation
- in_ctrl  input  3  ALU control code: 000 add, 001 sub, 010 and, 011 or, 101 slt
- in_a, in_b  input  VW  vector operands; lane i is bits [i*LANE_W +: LANE_W]
- flush  input  1  synchronous abort of any in-flight operation
- alu_en  output  1  shared ALU is driven this cycle
- alu_ctrl  output  3  control code to the shared ALU
- alu_a, alu_b  output  LANE_W  lane operands to the shared ALU
- alu_result  input  LANE_W  combinational result from the shared ALU, same cycle
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_result  output  VW  assembled result vector
- out_zero  output  1  1 when every bit of out_result is 0
- out_err  output  1  operation carried an unsupported control code

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture in_ctrl, in_a and in_b into internal registers, clear the result register, and set lane counter cnt=0.
  - Supported ctrl goes to RUN. Unsupported ctrl (100, 110, 111) goes straight to DONE with err=1 and the result left at 0.
- RUN:
  - alu_en=1, alu_ctrl=captured ctrl, alu_a/alu_b=captured lane cnt.
  - alu_result is written into result lane cnt at the clock edge.
  - cnt increments each cycle. When cnt==LANES-1, the next state is DONE and cnt wraps to 0.
- DONE:
  - out_valid=1. out_result, out_zero and out_err are held stable until out_ready=1.
  - On out_ready, the next state is IDLE.
  - A new operation is accepted no earlier than the cycle after the DONE handshake. There is no same-cycle DONE-to-accept bypass.
- Outside RUN, alu_en=0, alu_ctrl=000, alu_a=0 and alu_b=0.
- in_ready=0 in RUN and DONE. in_a, in_b and in_ctrl are ignored there.
- out_zero is computed from the result register only, as the NOR of all VW bits.
- out_err is cleared on every accepted operation.
- The sequencer performs no arithmetic. Lane results are taken verbatim from alu_result, and no carry propagates between lanes.
- flush:
  - Has priority over every other transition. Next state is IDLE, cnt=0, err=0.
  - The result register is not cleared; it is cleared on the next accept.
  - out_valid drops the next cycle.
  - flush together with in_valid in IDLE: the request is not accepted.

## Timing
- Reset (rst=0, asynchronous):
  - State=IDLE, cnt=0, result=0, err=0, captured ctrl/operands=0.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_result=0, out_zero=1, out_err=0, alu_en=0.
- Reset asserted mid-RUN or mid-DONE aborts immediately with no partial output.
- Supported op accepted at edge 0:
  - RUN lanes 0..LANES-1 occupy the cycles after edges 0..7.
  - out_valid=1 in the cycle after edge 8.
  - Latency is LANES+1 cycles from the accept edge to out_valid.
- Unsupported op: out_valid=1 in the cycle after the accept edge (latency 1).
- Best-case throughput: one operation per LANES+2 cycles with out_ready tied high.
- out_ready is sampled only in DONE. out_valid held with out_ready=0 persists indefinitely with stable data.

## Test plan
- Reset: hold rst=0 for 3 cycles mid-RUN, then release -> out_valid=0, out_zero=1, in_ready=1, alu_en=0; next op behaves normally.
- Add:
  - Stimulus: ctrl=000, in_a lane i=i+1, in_b lane i=0x10, out_ready=1, with a reference 32-bit ALU model on alu_*.
  - Required: alu_en high for exactly 8 cycles with alu_a=1..8 in order; out_valid 9 cycles after accept; out_result lane i=0x11+i; out_zero=0.
- Sub to zero: ctrl=001, in_a=in_b=all 0xA5 -> out_result=0, out_zero=1, out_err=0.
- Unsupported code: ctrl=110 -> alu_en never asserts; out_valid the next cycle; out_result=0, out_err=1, out_zero=1.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
  - Required: in_ready=0, out_result unchanged throughout; after out_ready=1, IDLE, then the new op is accepted one cycle later.
- Flush: assert flush at lane 4 of an or (ctrl=011) -> IDLE next cycle, out_valid never asserts, alu_en=0; a following op completes correctly with result cleared on accept.
